// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (LSB first) that oversamples the serial line
// with i_clk and samples each bit at its centre.
// Ports: i_clk, i_rst (sync, active-high), i_uart_mosi (async serial in),
//   o_data (last good byte), o_valid (1-cycle byte strobe),
//   o_frame_err (1-cycle stop-bit error strobe), o_busy (frame in progress).
// Option: define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote of
//   rx_s at div==2,1,0 (requires HALF_CNT>=2).
module uart_rx #(
   parameter int DIV_WID  = 9,
   parameter int DIV_CNT  = 433,
   parameter int HALF_CNT = DIV_CNT / 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_uart_mosi,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam logic [DIV_WID-1:0] DIV_V  = DIV_WID'(DIV_CNT);
   localparam logic [DIV_WID-1:0] HALF_V = DIV_WID'(HALF_CNT);
   localparam logic [DIV_WID-1:0] ONE_V  = DIV_WID'(1);
   localparam logic [DIV_WID-1:0] TWO_V  = DIV_WID'(2);

   logic [1:0]         state;
   logic [DIV_WID-1:0] div;
   logic [2:0]         bitcnt;
   logic [7:0]         shift;
   logic               rx_m;
   logic               rx_s;
   logic               rx_d;
   logic               sample;
   logic               dec;

   // Two-flop synchronizer plus one delay stage for edge detection.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= i_uart_mosi;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign dec = (div == '0);

`ifdef UART_RX_MAJORITY_EN
   logic maj_2;
   logic maj_1;

   // Capture the two samples preceding each decision point.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         maj_2 <= 1'b1;
         maj_1 <= 1'b1;
      end else if (state != IDLE) begin
         if (div == TWO_V) maj_2 <= rx_s;
         if (div == ONE_V) maj_1 <= rx_s;
      end
   end

   assign sample = (maj_2 & maj_1) | (maj_2 & rx_s) | (maj_1 & rx_s);
`else
   assign sample = rx_s;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         div         <= '0;
         bitcnt      <= 3'd0;
         shift       <= 8'h00;
         o_data      <= 8'h00;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         unique case (state)
            IDLE: begin
               div <= '0;
               if (rx_d && !rx_s) begin
                  state <= START;
                  div   <= HALF_V;
               end
            end
            START: begin
               if (!dec) begin
                  div <= div - ONE_V;
               end else if (!sample) begin
                  state  <= DATA;
                  div    <= DIV_V;
                  bitcnt <= 3'd0;
               end else begin
                  // False start: line was high again at mid-bit.
                  state <= IDLE;
               end
            end
            DATA: begin
               if (!dec) begin
                  div <= div - ONE_V;
               end else begin
                  shift  <= {sample, shift[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  div    <= DIV_V;
                  if (bitcnt == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (!dec) begin
                  div <= div - ONE_V;
               end else begin
                  state <= IDLE;
                  if (sample) begin
                     o_data  <= shift;
                     o_valid <= 1'b1;
                  end else begin
                     o_frame_err <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               div   <= '0;
            end
         endcase
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Expected bytes are queued at send time and checked on o_valid.
module tb_uart_rx;

   logic       clk;
   logic       rst;
   logic       mosi;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int last_valid_cyc = 0;
   bit busy_seen = 0;
   logic [7:0] exp_q[$];

   uart_rx #(
      .DIV_WID (9),
      .DIV_CNT (15)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_uart_mosi (mosi),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: sampled on the falling edge.
   always @(negedge clk) begin
      logic [7:0] e;
      if (o_valid === 1'b1) begin
         valid_cnt++;
         last_valid_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: o_data=%02h, no byte expected",
                     o_data);
         end else begin
            e = exp_q.pop_front();
            if (o_data !== e) begin
               errors++;
               $display("FAIL sb_data: o_data=%02h expected %02h",
                        o_data, e);
            end
         end
      end
      if (o_frame_err === 1'b1) ferr_cnt++;
      if (o_valid === 1'b1 && o_frame_err === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL both_pulses: valid=1 ferr=1 expected not both");
      end
      if (o_busy === 1'b1) busy_seen = 1'b1;
   end

   task automatic idle(input int n);
      mosi = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one 160-clock frame; glitch inverts the line for the
   // single clock at that offset (-1 for none). c0 = cycle of start edge.
   task automatic drive_frame(input logic [7:0] d, input logic stop,
                              input int glitch, output int c0);
      logic v;
      c0 = cyc;
      for (int i = 0; i < 160; i++) begin
         case (i / 16)
            0:       v = 1'b0;
            9:       v = stop;
            default: v = d[(i / 16) - 1];
         endcase
         mosi = (i == glitch) ? ~v : v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      mosi = 1'b1;
      rst  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (o_data !== 8'h00) begin
         errors++;
         $display("FAIL rst_data: got %02h expected 00", o_data);
      end
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid: got %b expected 0", o_valid);
      end
      checks++;
      if (o_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_ferr: got %b expected 0", o_frame_err);
      end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy: got %b expected 0", o_busy);
      end
      idle(10);
   endtask

   task automatic test_single;
      int c0, v0, f0;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      exp_q.push_back(8'h55);
      drive_frame(8'h55, 1'b1, -1, c0);
      idle(8);
      checks++;
      if (valid_cnt - v0 !== 1) begin
         errors++;
         $display("FAIL single_cnt: got %0d pulses expected 1",
                  valid_cnt - v0);
      end
      // 2 synchronizer clocks + HALF_CNT+1 + 9*16 decision + 1 register.
      checks++;
      if (last_valid_cyc - c0 !== 155) begin
         errors++;
         $display("FAIL single_lat: got %0d expected 155",
                  last_valid_cyc - c0);
      end
      checks++;
      if (ferr_cnt - f0 !== 0) begin
         errors++;
         $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0);
      end
   endtask

   task automatic test_back_to_back;
      int c0, c1, v0, t0;
      v0 = valid_cnt;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      drive_frame(8'hA5, 1'b1, -1, c0);
      t0 = last_valid_cyc;
      drive_frame(8'h3C, 1'b1, -1, c1);
      idle(8);
      checks++;
      if (valid_cnt - v0 !== 2) begin
         errors++;
         $display("FAIL b2b_cnt: got %0d expected 2", valid_cnt - v0);
      end
      checks++;
      if (last_valid_cyc - t0 !== 160) begin
         errors++;
         $display("FAIL b2b_gap: got %0d expected 160",
                  last_valid_cyc - t0);
      end
   endtask

   task automatic test_glitch;
      int v0, f0;
      logic [7:0] prev;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      prev = o_data;
      busy_seen = 1'b0;
      mosi = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      idle(40);
      checks++;
      if (busy_seen !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy_seen: got %b expected 1", busy_seen);
      end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy_end: got %b expected 0", o_busy);
      end
      checks++;
      if ((valid_cnt - v0) + (ferr_cnt - f0) !== 0) begin
         errors++;
         $display("FAIL glitch_pulses: got %0d expected 0",
                  (valid_cnt - v0) + (ferr_cnt - f0));
      end
      checks++;
      if (o_data !== prev) begin
         errors++;
         $display("FAIL glitch_data: got %02h expected %02h", o_data, prev);
      end
   endtask

   task automatic test_frame_err;
      int c0, v0, f0;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      drive_frame(8'hF0, 1'b0, -1, c0);
      mosi = 1'b0;
      repeat (640) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (ferr_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL ferr_cnt: got %0d expected 1", ferr_cnt - f0);
      end
      checks++;
      if (valid_cnt - v0 !== 0) begin
         errors++;
         $display("FAIL ferr_valid: got %0d expected 0", valid_cnt - v0);
      end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL ferr_break_busy: got %b expected 0", o_busy);
      end
      idle(32);
      exp_q.push_back(8'h12);
      drive_frame(8'h12, 1'b1, -1, c0);
      idle(8);
      checks++;
      if (o_data !== 8'h12) begin
         errors++;
         $display("FAIL ferr_recover: got %02h expected 12", o_data);
      end
      checks++;
      if (ferr_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL ferr_total: got %0d expected 1", ferr_cnt - f0);
      end
   endtask

   task automatic test_mid_reset;
      int v0, f0, c0;
      logic [7:0] d;
      d = 8'hC3;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      // Drive up to the middle of data bit 4, then abort.
      for (int i = 0; i < 88; i++) begin
         mosi = (i < 16) ? 1'b0 : d[(i / 16) - 1];
         @(posedge clk);
         #1;
      end
      mosi = 1'b1;
      rst  = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({o_data, o_valid, o_frame_err, o_busy} !== 11'h000) begin
         errors++;
         $display("FAIL midrst_outs: got %02h/%b/%b/%b expected 00/0/0/0",
                  o_data, o_valid, o_frame_err, o_busy);
      end
      idle(200);
      checks++;
      if ((valid_cnt - v0) + (ferr_cnt - f0) !== 0) begin
         errors++;
         $display("FAIL midrst_pulses: got %0d expected 0",
                  (valid_cnt - v0) + (ferr_cnt - f0));
      end
      exp_q.push_back(8'h81);
      drive_frame(8'h81, 1'b1, -1, c0);
      idle(8);
      checks++;
      if (o_data !== 8'h81) begin
         errors++;
         $display("FAIL midrst_next: got %02h expected 81", o_data);
      end
   endtask

   task automatic test_majority;
      int c0;
      logic [7:0] e;
`ifdef UART_RX_MAJORITY_EN
      e = 8'h00;
`else
      e = 8'h08;
`endif
      exp_q.push_back(e);
      // Offset 72 puts the one-clock glitch on rx_s at the bit-3 decision.
      drive_frame(8'h00, 1'b1, 72, c0);
      idle(8);
      checks++;
      if (o_data !== e) begin
         errors++;
         $display("FAIL majority: got %02h expected %02h", o_data, e);
      end
   endtask

   initial begin
      rst  = 1'b1;
      mosi = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_mid_reset();
      test_majority();
      idle(20);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d queued expected 0",
                  exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
